// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Defining MDU_FAST_MUL_EN swaps the multiply path for a single-cycle combinational multiplier.
module mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  func,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic        neg;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic [31:0] rem;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        accept, div_zero, div_ovf, special;
  logic [31:0] special_res;
  logic        fast_sel;
  logic [31:0] fast_res;

  assign a_signed = (func != 3'd3) && (func != 3'd5) && (func != 3'd7);
  assign b_signed = a_signed && (func != 3'd2);
  assign a_neg    = a_signed && src_a[31];
  assign b_neg    = b_signed && src_b[31];
  assign mag_a    = a_neg ? (~src_a + 32'd1) : src_a;
  assign mag_b    = b_neg ? (~src_b + 32'd1) : src_b;

  assign accept      = start && (state != CALC);
  assign div_zero    = func[2] && (src_b == 32'd0);
  assign div_ovf     = func[2] && !func[0] && (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (func[1] ? src_a : 32'hFFFF_FFFF)
                                : (func[1] ? 32'd0 : 32'h8000_0000);

`ifdef MDU_FAST_MUL_EN
  // Operands extended to 64 bits; the low 64 bits of the product are exact for every variant.
  logic [63:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{32{a_neg}}, src_a};
  assign fast_b    = {{32{b_neg}}, src_b};
  assign fast_prod = fast_a * fast_b;
  assign fast_sel  = !func[2];
  assign fast_res  = (func == 3'd0) ? fast_prod[31:0] : fast_prod[63:32];
`else
  assign fast_sel  = 1'b0;
  assign fast_res  = 32'd0;
`endif

  // One iteration of each datapath; acc[31:0] holds multiplier or dividend/quotient.
  logic [32:0] mul_sum;
  logic [63:0] mul_nx, div_nx, acc_nx, prod;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        qbit;
  logic [31:0] rem_nx, quo, fin;

  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_nx  = {mul_sum, acc[31:1]};
  assign shifted = {rem, acc[31]};
  assign diff    = {1'b0, shifted} - {2'b00, opnd};
  assign qbit    = !diff[33];
  assign rem_nx  = qbit ? diff[31:0] : shifted[31:0];
  assign div_nx  = {acc[63:32], acc[30:0], qbit};
  assign acc_nx  = op[2] ? div_nx : mul_nx;
  assign prod    = neg ? (~mul_nx + 64'd1) : mul_nx;
  assign quo     = div_nx[31:0];

  always_comb begin
    fin = 32'd0;
    case (op)
      3'd0:                fin = prod[31:0];
      3'd1, 3'd2, 3'd3:    fin = prod[63:32];
      3'd4, 3'd5:          fin = neg ? (~quo + 32'd1) : quo;
      default:             fin = neg ? (~rem_nx + 32'd1) : rem_nx;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start)           state_nx = (special || fast_sel) ? DONE : CALC;
        else                 state_nx = IDLE;
      end
      CALC:    if (cnt == 5'd0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 5'd0;
      op     <= 3'd0;
      neg    <= 1'b0;
      opnd   <= 32'd0;
      acc    <= 64'd0;
      rem    <= 32'd0;
      result <= 32'd0;
    end else if (flush) begin
      cnt <= 5'd0;
    end else if (accept) begin
      op <= func;
      if (special) begin
        result <= special_res;
      end else if (fast_sel) begin
        result <= fast_res;
      end else begin
        cnt  <= 5'd31;
        neg  <= (func[2] && func[1]) ? a_neg : (a_neg ^ b_neg);
        opnd <= func[2] ? mag_b : mag_a;
        acc  <= {32'd0, func[2] ? mag_a : mag_b};
        rem  <= 32'd0;
      end
    end else if (state == CALC) begin
      acc <= acc_nx;
      rem <= rem_nx;
      cnt <= cnt - 5'd1;
      if (cnt == 5'd0) result <= fin;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: driver tasks push expected result and done cycle; a negedge monitor checks them.
module tb_mdu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  func;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  mdu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .func   (func),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];
  int          when_q[$];
  string       name_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with result %08h expected no done (cyc=%0d)", result, cyc);
      end else begin
        string       n;
        logic [31:0] e;
        int          w;
        n = name_q.pop_front();
        e = exp_q.pop_front();
        w = when_q.pop_front();
        check({n, "_result"}, result, e);
        check({n, "_cycle"}, 32'(cyc), 32'(w));
      end
    end
  end

  // driver: call at a negedge; the next posedge is the accept edge
  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input int lat, input bit track);
    func  = f;
    src_a = a;
    src_b = b;
    start = 1'b1;
    if (track) begin
      name_q.push_back(name);
      exp_q.push_back(e);
      when_q.push_back(cyc + lat);
    end
    @(negedge clk);
    start = 1'b0;
    func  = 3'($urandom_range(0, 7));
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic wait_done(input string name, input bit no_busy);
    int i;
    bit seen_busy;
    i = 0;
    seen_busy = 1'b0;
    forever begin
      #1;
      if (busy) seen_busy = 1'b1;
      if (exp_q.size() == 0) break;
      if (i >= 60) begin
        check({name, "_timeout"}, 32'd0, 32'd1);
        exp_q.delete();
        when_q.delete();
        name_q.delete();
        break;
      end
      i++;
      @(negedge clk);
    end
    if (no_busy) check({name, "_busy_seen"}, {31'd0, seen_busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e, input int lat);
    issue(name, f, a, b, e, lat, 1'b1);
    wait_done(name, lat == 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    func  = 3'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);

    run("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
    run("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
    run("divu",   3'd5, 32'd100,        32'd7,         32'd14,        DIV_LAT);
    run("remu",   3'd7, 32'd100,        32'd7,         32'd2,         DIV_LAT);
    run("divu_z", 3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run("remu_z", 3'd7, 32'd5,          32'd0,         32'd5,         1);
    run("div_ov", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ov", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // start at cycle 5 of an active DIV is dropped
    issue("div_ign", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
    repeat (4) @(negedge clk);
    func  = 3'd5;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("div_ign", 1'b0);

    // flush at cycle 10: no done, result keeps the previous value
    issue("flush", 3'd7, 32'd100, 32'd7, 32'd0, DIV_LAT, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_result", result, 32'hFFFF_FFFD);

    // back-to-back: second start lands in the DONE cycle of the first
    issue("b2b_1", 3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1);
    repeat (32) @(negedge clk);
    issue("b2b_2", 3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, 1'b1);
    wait_done("b2b", 1'b0);

    // asynchronous reset at cycle 15 of a DIVU
    issue("rst_op", 3'd5, 32'd1000, 32'd3, 32'd333, DIV_LAT, 1'b0);
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("post_rst", 3'd5, 32'd1000, 32'd3, 32'd333, DIV_LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative RV32M multiply/divide unit in the Otter execute stage. It takes the same `src_a`/`src_b` operands as the ALU. Its `result` feeds the writeback result mux alongside the ALU output. The control unit stalls the pipeline while `busy` is high and captures `result` on `done`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request pulse; operands and `func` are sampled on this edge.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `func`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src_a`  in  32  rs1 operand: multiplicand or dividend.
- `src_b`  in  32  rs2 operand: multiplier or divisor.
- `busy`  out  1  high in CALC; new `start` is ignored.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  32  final value; held until the next accepted `start`.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **IDLE/DONE, `start`=1:** latch `func` and operand magnitudes, plus the result sign.
  - Go to CALC with counter = 31.
  - Special cases go straight to DONE instead.
- **IDLE/DONE, `start`=0:** DONE returns to IDLE; IDLE holds.
- **CALC:** one iteration per cycle. At counter = 0, apply sign correction, write `result`, go to DONE.
- **Sign rules:**
  - MUL, MULH: both operands signed.
  - MULHSU: `src_a` signed, `src_b` unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV: quotient sign = sign(a) XOR sign(b).
  - REM: remainder takes the sign of the dividend.
- **Multiply:** shift-add of magnitudes into a 64-bit accumulator. The accumulator is negated (64-bit two's complement) when the product sign is negative.
  - MUL returns bits [31:0].
  - MULH, MULHSU, MULHU return bits [63:32].
- **Divide:** restoring division, 32 iterations, 32-bit quotient and 33-bit partial remainder.
- **Special cases (no iteration):**
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return `src_a`.
  - Signed overflow (DIV with `src_a`=0x80000000, `src_b`=0xFFFFFFFF): returns 0x80000000; REM returns 0.
- **`flush`:** from any state, go to IDLE. No `done` pulse; `result` is unchanged. `flush` has priority over `start` in the same cycle.
- **Reset values:** state IDLE, `busy`=0, `done`=0, `result`=0, counter 0, accumulators 0.

## Timing
- Accept edge = cycle 0.
- Iterative operation:
  - `busy`=1 for cycles 1–32.
  - `done`=1 and `result` valid in cycle 33.
- Special-case divide: `done` in cycle 1, `busy` never asserted.
- `start` in the DONE cycle is accepted, giving back-to-back operations with no idle gap.
- `start` while `busy`=1 is dropped silently. The control unit must hold the pipeline until `done`.
- Operands need only be stable on the accept edge.
- `result` is registered: no combinational path from inputs to outputs.
- Reset asserted mid-operation clears everything immediately (asynchronous). No `done` follows.

## Configuration
- **`MDU_FAST_MUL_EN` defined:**
  - MUL/MULH/MULHSU/MULHU use a single 33×33 signed combinational multiplier (operands sign- or zero-extended per `func`).
  - The product is registered at the accept edge and the FSM goes straight to DONE: `done` in cycle 1, `busy` never asserted.
  - Division is unchanged.
- **Undefined (default):** all multiplies use the 32-iteration shift-add path, with the same latency as divide (`done` in cycle 33).

## Test plan
- **MUL:** `func`=0, `src_a`=7, `src_b`=0xFFFFFFFD → `result`=0xFFFFFFEB. `done` in cycle 33, or cycle 1 with `MDU_FAST_MUL_EN`.
- **High products:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 % 7 → 2.
- **Special cases (`done` in cycle 1, `busy` never high):**
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- **Control:**
  - `start` at cycle 5 of an active DIV is ignored; the original result arrives in cycle 33.
  - `flush` at cycle 10 gives no `done` and keeps the previous `result`.
  - Back-to-back `start` in the DONE cycle completes 33 cycles later.
- **Reset:** `rst_n` low at cycle 15 of a DIVU → `busy`, `done`, `result` = 0 asynchronously. The next `start` after release completes correctly.
